// File: rtl/mest_pro_run_seq.sv
// Processor run sequencer: pulses memory reset and start for NUM_RUNS runs, captures results,
// folds them into a rotating signature and compares it against a golden value.
module mest_pro_run_seq #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned SIG_WIDTH        = 16,
  parameter int unsigned NUM_RUNS         = 4,
  parameter int unsigned MAX_RESULTS      = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 1024,
  parameter int unsigned RST_PULSE_CYCLES = 2,
  localparam int unsigned IdxW = (MAX_RESULTS > 1) ? $clog2(MAX_RESULTS) : 1,
  localparam int unsigned CntW = IdxW + 1,
  localparam int unsigned RunW = $clog2(NUM_RUNS) + 1
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_go,
  input  logic [SIG_WIDTH-1:0]  i_expected_sig,
  output logic                  o_memory_reset,
  output logic                  o_start,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic                  i_valid_result,
  input  logic                  i_carry,
  input  logic                  i_zero_flag,
  input  logic                  i_all_done,
  input  logic [IdxW-1:0]       i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic                  o_overflow,
  output logic [CntW-1:0]       o_result_count,
  output logic [RunW-1:0]       o_run_count,
  output logic [SIG_WIDTH-1:0]  o_signature
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned PulW = $clog2(RST_PULSE_CYCLES) + 1;

  typedef enum logic [2:0] {StIdle, StMrst, StStart, StRun, StCheck, StDone} state_e;

  state_e                state_q, state_d;
  logic [PulW-1:0]       pulse_q;
  logic [TmrW-1:0]       tmr_q;
  logic [SIG_WIDTH-1:0]  sig_q;
  logic [CntW-1:0]       cnt_q;
  logic [RunW-1:0]       run_q;
  logic                  pass_q, timeout_q, overflow_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] mem [MAX_RESULTS];

  logic                 pulse_last, tmr_expired, run_last, cap_en;
  logic [SIG_WIDTH-1:0] sig_in;

  assign pulse_last  = (pulse_q == PulW'(RST_PULSE_CYCLES - 1));
  assign tmr_expired = (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));
  assign run_last    = ((32'(run_q) + 32'd1) >= NUM_RUNS);
  assign cap_en      = (state_q == StRun) && i_valid_result && (32'(cnt_q) < MAX_RESULTS);
  assign sig_in      = SIG_WIDTH'({i_carry, i_zero_flag, i_result});

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (i_go) state_d = StMrst;
      StMrst:         if (pulse_last) state_d = StStart;
      StStart:        state_d = StRun;
      StRun: begin
        if (i_all_done)       state_d = run_last ? StCheck : StMrst;
        else if (tmr_expired) state_d = StDone;
      end
      StCheck:        state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    o_memory_reset = (state_q == StMrst);
    o_start        = (state_q == StStart);
    o_busy         = (state_q == StMrst) || (state_q == StStart) ||
                     (state_q == StRun)  || (state_q == StCheck);
    o_done         = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      pulse_q    <= '0;
      tmr_q      <= '0;
      sig_q      <= '0;
      cnt_q      <= '0;
      run_q      <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pulse_q <= (state_q == StMrst) ? pulse_q + PulW'(1) : '0;
      case (state_q)
        StIdle, StDone: begin
          if (i_go) begin
            sig_q      <= '0;
            cnt_q      <= '0;
            run_q      <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
          end
        end
        StStart: tmr_q <= '0;
        StRun: begin
          tmr_q <= tmr_q + TmrW'(1);
          if (i_valid_result) begin
            sig_q <= {sig_q[SIG_WIDTH-2:0], sig_q[SIG_WIDTH-1]} ^ sig_in;
            if (cap_en) cnt_q <= cnt_q + CntW'(1);
            else        overflow_q <= 1'b1;
          end
          if (i_all_done) begin
            run_q <= run_q + RunW'(1);
          end else if (tmr_expired) begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end
        end
        StCheck: pass_q <= (sig_q == i_expected_sig) && !overflow_q;
        default: ;
      endcase
    end
  end

  // Buffer storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (cap_en) mem[cnt_q[IdxW-1:0]] <= i_result;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) rd_q <= '0;
    else         rd_q <= mem[i_rd_idx];
  end

  assign o_rd_data      = rd_q;
  assign o_pass         = pass_q;
  assign o_timeout      = timeout_q;
  assign o_overflow     = overflow_q;
  assign o_result_count = cnt_q;
  assign o_run_count    = run_q;
  assign o_signature    = sig_q;

endmodule

// File: doc/mest_pro_run_seq.md
MEST_PRO_RUN_SEQ -- requirements
Module: mest_pro_run_seq

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 8, width of the processor result bus.
- SIG_WIDTH, 16, signature width; the block SHALL require DATA_WIDTH+2 <= SIG_WIDTH.
- NUM_RUNS, 4, number of reset/start/complete runs per sequence, >= 1.
- MAX_RESULTS, 16, depth of the result capture buffer, power of two.
- TIMEOUT_CYCLES, 1024, maximum RUN-state cycles per run.
- RST_PULSE_CYCLES, 2, o_memory_reset pulse length, >= 1.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state SHALL update on its rising edge.
- i_reset, in, 1, asynchronous active-high reset.
- i_go, in, 1, single-cycle sequence request.
- i_expected_sig, in, SIG_WIDTH, golden signature, sampled in CHECK.
- o_memory_reset, out, 1, memory reset drive to processor.
- o_start, out, 1, start pulse to processor.
- i_result, in, DATA_WIDTH, processor result.
- i_valid_result, in, 1, result qualifier.
- i_carry, in, 1, processor carry flag.
- i_zero_flag, in, 1, processor zero flag.
- i_all_done, in, 1, processor program-complete flag.
- i_rd_idx, in, log2(MAX_RESULTS), buffer read index.
- o_rd_data, out, DATA_WIDTH, buffer entry at i_rd_idx, registered one cycle.
- o_busy, o_done, o_pass, o_timeout, o_overflow, out, 1 each, status flags.
- o_result_count, out, log2(MAX_RESULTS)+1, entries captured.
- o_run_count, out, log2(NUM_RUNS)+1, runs completed.
- o_signature, out, SIG_WIDTH, running signature.

Function
REQ-003 FSM states SHALL be IDLE, MRST, START, RUN, CHECK, DONE.
REQ-004 IDLE or DONE with i_go=1 -> MRST; SHALL clear signature, counters, o_done, o_pass, o_timeout, o_overflow.
REQ-005 MRST: o_memory_reset=1 for exactly RST_PULSE_CYCLES cycles, then -> START.
REQ-006 START: o_start=1 for exactly one cycle, run timer cleared, then -> RUN.
REQ-007 RUN: each cycle with i_valid_result=1, signature SHALL become rotl1(sig) XOR zero-extended {i_carry, i_zero_flag, i_result}.
REQ-008 RUN: a valid result SHALL be written to buffer[o_result_count] and the count incremented while count < MAX_RESULTS; otherwise o_overflow SHALL set and stay set; the signature still updates.
REQ-009 RUN with i_all_done=1 SHALL increment o_run_count after any same-cycle capture, then -> MRST if runs < NUM_RUNS, else -> CHECK.
REQ-010 RUN timer SHALL count RUN cycles; if TIMEOUT_CYCLES elapse without i_all_done, the block SHALL set o_timeout=1 and o_pass=0 and go -> DONE, skipping CHECK.
REQ-011 CHECK, one cycle: o_pass = (o_signature == i_expected_sig) AND NOT o_overflow; then -> DONE.
REQ-012 DONE: o_done=1, status held until next i_go.
REQ-013 o_busy SHALL be 1 in MRST, START, RUN, CHECK; i_go SHALL be ignored while busy.
REQ-014 i_valid_result and i_all_done SHALL be ignored outside RUN.
REQ-015 The buffer SHALL be readable in any state; entries at or above o_result_count SHALL read stale data, with no error.

Reset
REQ-016 i_reset SHALL force, immediately and asynchronously, state IDLE and all outputs, counters, and signature to 0; buffer contents are undefined.
REQ-017 i_reset mid-sequence SHALL abort the sequence with no o_done pulse; deasserting o_start and o_memory_reset is immediate.

Verification
REQ-018 Defaults, NUM_RUNS=1, i_go; DUT gives results 0x05 then 0x0A (flags 0), then all_done; expected_sig 0x0000 -> o_memory_reset high for 2 cycles, one o_start pulse, o_signature=0x0000, o_pass=1, o_result_count=2, buffer[0]=0x05, buffer[1]=0x0A.
REQ-019 NUM_RUNS=4, one result 0x00 per run with zero_flag=1 -> four MRST/START pairs, o_run_count=4, o_signature=0x0F00.
REQ-020 TIMEOUT_CYCLES=8, i_all_done never asserted -> o_timeout=1, o_pass=0, o_done=1 after 8 RUN cycles.
REQ-021 MAX_RESULTS=4, six valid results in one run -> o_result_count=4, o_overflow=1, o_pass=0 even with matching signature.
REQ-022 i_valid_result and i_all_done in the same cycle -> result captured and run counted. i_go during RUN -> ignored. i_reset during RUN -> all outputs 0 within the same cycle.
